// File: rtl/midi_rx_parser.sv
// MIDI 8N1 receiver with Note On/Off parser (running status) and a one-entry valid/ready output.
// Optional define MIDI_CHANNEL_FILTER_EN restricts note status bytes to channel CHANNEL.
module midi_rx_parser #(
  parameter int CLKS_PER_BIT = 320,
  parameter int CHANNEL      = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ser_in,
  input  logic       evt_ready,
  output logic       evt_valid,
  output logic       evt_note_on,
  output logic [6:0] evt_note,
  output logic [6:0] evt_vel,
  output logic       frame_err,
  output logic       overrun
);

  localparam int          HALF = CLKS_PER_BIT / 2;
  localparam int          CW   = $clog2(CLKS_PER_BIT);
  localparam logic [3:0]  CHAN = 4'(CHANNEL);
`ifdef MIDI_CHANNEL_FILTER_EN
  localparam bit          OMNI = 1'b0;
`else
  localparam bit          OMNI = 1'b1;
`endif

  typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_state_e;
  typedef enum logic [1:0] {P_WAIT_STATUS, P_WAIT_NOTE, P_WAIT_VEL} parse_state_e;

  logic          sync1_q, sync2_q;
  uart_state_e   u_state_q, u_state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  parse_state_e  p_state_q, p_state_d;
  logic          rs_valid_q, rs_valid_d;
  logic          rs_is_on_q, rs_is_on_d;
  logic [6:0]    note_q, note_d;
  logic          evt_valid_q, evt_valid_d;
  logic          evt_on_q, evt_on_d;
  logic [6:0]    evt_note_q, evt_note_d;
  logic [6:0]    evt_vel_q, evt_vel_d;
  logic          frame_err_q, frame_err_d;
  logic          overrun_q, overrun_d;

  logic          rx;
  logic          byte_valid, stop_err, chan_ok;
  logic          new_evt, new_on;
  logic [6:0]    new_vel;

  assign rx      = sync2_q;
  assign chan_ok = OMNI || (shift_q[3:0] == CHAN);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    u_state_d  = u_state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    byte_valid = 1'b0;
    stop_err   = 1'b0;
    case (u_state_q)
      U_IDLE: begin
        if (!rx) begin
          u_state_d = U_START;
          cnt_d     = '0;
        end
      end
      U_START: begin
        if (cnt_q == CW'(HALF - 1)) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          u_state_d = rx ? U_IDLE : U_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      U_DATA: begin
        if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
          cnt_d     = '0;
          shift_d   = {rx, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) u_state_d = U_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      U_STOP: begin
        if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
          cnt_d      = '0;
          u_state_d  = U_IDLE;
          byte_valid = rx;
          stop_err   = !rx;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: u_state_d = U_IDLE;
    endcase
  end

  // Parser consumes the completed byte straight out of the shift register.
  always_comb begin
    p_state_d  = p_state_q;
    rs_valid_d = rs_valid_q;
    rs_is_on_d = rs_is_on_q;
    note_d     = note_q;
    new_evt    = 1'b0;
    new_on     = 1'b0;
    new_vel    = '0;
    if (stop_err) begin
      rs_valid_d = 1'b0;
      p_state_d  = P_WAIT_STATUS;
    end else if (byte_valid) begin
      if (shift_q >= 8'hF8) begin
        p_state_d = p_state_q;
      end else if (shift_q >= 8'hF0) begin
        rs_valid_d = 1'b0;
        p_state_d  = P_WAIT_STATUS;
      end else if (shift_q[7]) begin
        if (shift_q[7:5] == 3'b100 && chan_ok) begin
          rs_valid_d = 1'b1;
          rs_is_on_d = shift_q[4];
          p_state_d  = P_WAIT_NOTE;
        end else begin
          rs_valid_d = 1'b0;
          p_state_d  = P_WAIT_STATUS;
        end
      end else begin
        case (p_state_q)
          P_WAIT_STATUS: begin
            if (rs_valid_q) begin
              note_d    = shift_q[6:0];
              p_state_d = P_WAIT_VEL;
            end
          end
          P_WAIT_NOTE: begin
            note_d    = shift_q[6:0];
            p_state_d = P_WAIT_VEL;
          end
          P_WAIT_VEL: begin
            new_evt   = 1'b1;
            new_on    = rs_is_on_q && (shift_q[6:0] != 7'd0);
            new_vel   = new_on ? shift_q[6:0] : 7'd0;
            p_state_d = P_WAIT_NOTE;
          end
          default: p_state_d = P_WAIT_STATUS;
        endcase
      end
    end
  end

  // A transfer frees the slot in the same cycle, so a new event may load on it.
  always_comb begin
    evt_valid_d = evt_valid_q;
    evt_on_d    = evt_on_q;
    evt_note_d  = evt_note_q;
    evt_vel_d   = evt_vel_q;
    overrun_d   = 1'b0;
    frame_err_d = stop_err;
    if (evt_valid_q && evt_ready) evt_valid_d = 1'b0;
    if (new_evt) begin
      if (!evt_valid_q || evt_ready) begin
        evt_valid_d = 1'b1;
        evt_on_d    = new_on;
        evt_note_d  = note_q;
        evt_vel_d   = new_vel;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      u_state_q   <= U_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      p_state_q   <= P_WAIT_STATUS;
      rs_valid_q  <= 1'b0;
      rs_is_on_q  <= 1'b0;
      note_q      <= '0;
      evt_valid_q <= 1'b0;
      evt_on_q    <= 1'b0;
      evt_note_q  <= '0;
      evt_vel_q   <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync1_q     <= ser_in;
      sync2_q     <= sync1_q;
      u_state_q   <= u_state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      p_state_q   <= p_state_d;
      rs_valid_q  <= rs_valid_d;
      rs_is_on_q  <= rs_is_on_d;
      note_q      <= note_d;
      evt_valid_q <= evt_valid_d;
      evt_on_q    <= evt_on_d;
      evt_note_q  <= evt_note_d;
      evt_vel_q   <= evt_vel_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign evt_valid   = evt_valid_q;
  assign evt_note_on = evt_on_q;
  assign evt_note    = evt_note_q;
  assign evt_vel     = evt_vel_q;
  assign frame_err   = frame_err_q;
  assign overrun     = overrun_q;

endmodule
